// File: rtl/cmd_pkg.sv
// Shared definitions for the compressed command format: op codes, word count,
// field bit positions (also used by csb) and the descriptor shadow type.
package cmd_pkg;

  localparam int unsigned CMD_WORDS = 6;
  localparam int unsigned MAX_CMDS  = 127;

  localparam logic [2:0] OP_IDLE    = 3'd0;
  localparam logic [2:0] OP_CONV1   = 3'd1;
  localparam logic [2:0] OP_CONV2   = 3'd2;
  localparam logic [2:0] OP_CONV3   = 3'd3;
  localparam logic [2:0] OP_MAXPOOL = 3'd4;
  localparam logic [2:0] OP_AVEPOOL = 3'd5;

  // Field positions inside w0..w2
  localparam int unsigned W0_OP_TYPE_LSB = 0;
  localparam int unsigned W0_PAD_BIT     = 4;
  localparam int unsigned W0_STRIDE_LSB  = 8;
  localparam int unsigned W0_OP_NUM_LSB  = 12;
  localparam int unsigned W1_I_CH_LSB    = 0;
  localparam int unsigned W1_O_CH_LSB    = 16;
  localparam int unsigned W2_I_SIDE_LSB  = 0;
  localparam int unsigned W2_O_SIDE_LSB  = 8;
  localparam int unsigned W2_SURF_LSB    = 16;

  typedef struct packed {
    logic [2:0]  op_type;
    logic        padding;
    logic [3:0]  stride;
    logic [19:0] op_num;
    logic [15:0] i_channel_size;
    logic [15:0] o_channel_size;
    logic [7:0]  i_side_size;
    logic [7:0]  o_side_size;
    logic [15:0] o_surf_size;
    logic [31:0] weight_start_addr;
    logic [31:0] data_start_addr;
    logic [31:0] result_addr;
  } desc_t;

  typedef enum logic [1:0] {StIdle, StEmit, StDone, StArmed} state_e;

  function automatic logic op_is_valid(input logic [2:0] op);
    return (op >= OP_CONV1) && (op <= OP_AVEPOOL);
  endfunction

endpackage

// File: rtl/cmd_pack.sv
// Combinational formatter: selects one 32-bit word of the packed command
// from the captured descriptor.
module cmd_pack
  import cmd_pkg::*;
(
  input  desc_t       desc,
  input  logic [2:0]  word_idx,
  output logic [31:0] word
);

  always_comb begin
    word = '0;
    case (word_idx)
      3'd0: begin
        word[W0_OP_TYPE_LSB +: 3] = desc.op_type;
        word[W0_PAD_BIT]          = desc.padding;
        word[W0_STRIDE_LSB +: 4]  = desc.stride;
        word[W0_OP_NUM_LSB +: 20] = desc.op_num;
      end
      3'd1: begin
        word[W1_I_CH_LSB +: 16] = desc.i_channel_size;
        word[W1_O_CH_LSB +: 16] = desc.o_channel_size;
      end
      3'd2: begin
        word[W2_I_SIDE_LSB +: 8] = desc.i_side_size;
        word[W2_O_SIDE_LSB +: 8] = desc.o_side_size;
        word[W2_SURF_LSB +: 16]  = desc.o_surf_size;
      end
      3'd3:    word = desc.weight_start_addr;
      3'd4:    word = desc.data_start_addr;
      3'd5:    word = desc.result_addr;
      default: word = '0;
    endcase
  end

endmodule

// File: rtl/cmd_writer.sv
// Host-side command encoder: accepts layer descriptors, writes 6-word commands
// into csb's command FIFO, and starts csb with op_en once the batch closes.
module cmd_writer
  import cmd_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        desc_valid,
  output logic        desc_ready,
  input  logic        desc_last,
  input  logic [2:0]  op_type,
  input  logic        padding,
  input  logic [3:0]  stride,
  input  logic [19:0] op_num,
  input  logic [15:0] i_channel_size,
  input  logic [15:0] o_channel_size,
  input  logic [7:0]  i_side_size,
  input  logic [7:0]  o_side_size,
  input  logic [15:0] o_surf_size,
  input  logic [31:0] weight_start_addr,
  input  logic [31:0] data_start_addr,
  input  logic [31:0] result_addr,
  input  logic        batch_clr,
  input  logic        cmd_fifo_full,
  output logic        cmd_fifo_wr_en,
  output logic [31:0] cmd_fifo_din,
  output logic [6:0]  cmd_size,
  output logic        op_en,
  output logic        busy,
  output logic        err
);

  state_e      state_q, state_d;
  desc_t       desc_q, desc_d, desc_in;
  logic        last_q, last_d;
  logic [2:0]  word_idx_q, word_idx_d;
  logic [6:0]  cmd_size_q, cmd_size_d;
  logic        err_q, err_d;
  logic        at_limit;
  logic [31:0] packed_word;

  assign desc_in = '{op_type: op_type, padding: padding, stride: stride, op_num: op_num,
                     i_channel_size: i_channel_size, o_channel_size: o_channel_size,
                     i_side_size: i_side_size, o_side_size: o_side_size,
                     o_surf_size: o_surf_size, weight_start_addr: weight_start_addr,
                     data_start_addr: data_start_addr, result_addr: result_addr};

  assign at_limit = (cmd_size_q == 7'(MAX_CMDS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      desc_q     <= '0;
      last_q     <= 1'b0;
      word_idx_q <= '0;
      cmd_size_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      desc_q     <= desc_d;
      last_q     <= last_d;
      word_idx_q <= word_idx_d;
      cmd_size_q <= cmd_size_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    desc_d     = desc_q;
    last_d     = last_q;
    word_idx_d = word_idx_q;
    cmd_size_d = cmd_size_q;
    err_d      = err_q;
    case (state_q)
      StIdle: begin
        if (desc_valid) begin
          desc_d     = desc_in;
          last_d     = desc_last;
          word_idx_d = '0;
          if (op_is_valid(op_type)) begin
            state_d = StEmit;
          end else begin
            // Invalid op: swallowed without writing, only flagged
            err_d   = 1'b1;
            state_d = desc_last ? StDone : StIdle;
          end
        end
      end
      StEmit: begin
        if (!cmd_fifo_full) begin
          if (word_idx_q == 3'(CMD_WORDS - 1)) begin
            cmd_size_d = cmd_size_q + 7'd1;
            state_d    = (last_q || at_limit) ? StDone : StIdle;
            if (at_limit && !last_q) err_d = 1'b1;
          end else begin
            word_idx_d = word_idx_q + 3'd1;
          end
        end
      end
      StDone: state_d = StArmed;
      StArmed: begin
        if (batch_clr) begin
          cmd_size_d = '0;
          err_d      = 1'b0;
          state_d    = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  cmd_pack u_cmd_pack (
    .desc     (desc_q),
    .word_idx (word_idx_q),
    .word     (packed_word)
  );

  always_comb begin
    desc_ready     = (state_q == StIdle);
    cmd_fifo_wr_en = (state_q == StEmit) && !cmd_fifo_full;
    cmd_fifo_din   = (state_q == StEmit) ? packed_word : '0;
    op_en          = (state_q == StDone);
    busy           = (state_q != StIdle);
  end

  assign cmd_size = cmd_size_q;
  assign err      = err_q;

endmodule

// File: tb/tb_cmd_writer.sv
// Directed bench for cmd_writer: a vector table of descriptors with hand-packed
// words, plus sequences for back-to-back, stall, invalid op, overflow and reset.
module tb_cmd_writer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        desc_valid = 1'b0, desc_ready, desc_last = 1'b0;
  logic [2:0]  op_type = '0;
  logic        padding = 1'b0;
  logic [3:0]  stride = '0;
  logic [19:0] op_num = '0;
  logic [15:0] i_channel_size = '0, o_channel_size = '0, o_surf_size = '0;
  logic [7:0]  i_side_size = '0, o_side_size = '0;
  logic [31:0] weight_start_addr = '0, data_start_addr = '0, result_addr = '0;
  logic        batch_clr = 1'b0, cmd_fifo_full = 1'b0;
  logic        cmd_fifo_wr_en, op_en, busy, err;
  logic [31:0] cmd_fifo_din;
  logic [6:0]  cmd_size;

  cmd_writer dut (
    .clk (clk), .rst (rst), .desc_valid (desc_valid), .desc_ready (desc_ready),
    .desc_last (desc_last), .op_type (op_type), .padding (padding), .stride (stride),
    .op_num (op_num), .i_channel_size (i_channel_size), .o_channel_size (o_channel_size),
    .i_side_size (i_side_size), .o_side_size (o_side_size), .o_surf_size (o_surf_size),
    .weight_start_addr (weight_start_addr), .data_start_addr (data_start_addr),
    .result_addr (result_addr), .batch_clr (batch_clr), .cmd_fifo_full (cmd_fifo_full),
    .cmd_fifo_wr_en (cmd_fifo_wr_en), .cmd_fifo_din (cmd_fifo_din), .cmd_size (cmd_size),
    .op_en (op_en), .busy (busy), .err (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]       op;
    logic             pad;
    logic [3:0]       stride;
    logic [19:0]      op_num;
    logic [15:0]      ich, och;
    logic [7:0]       iside, oside;
    logic [15:0]      surf;
    logic [31:0]      wa, da, ra;
    logic [0:5][31:0] exp;
  } vec_t;

  vec_t vecs[4];

  int errors = 0, checks = 0, cyc = 0;
  logic [31:0] wq[$];
  int wc[$];
  int op_cnt = 0, op_cyc = -1;

  always @(posedge clk) cyc <= cyc + 1;

  // FIFO-side monitor
  always @(negedge clk) begin
    if (cmd_fifo_wr_en) begin
      wq.push_back(cmd_fifo_din);
      wc.push_back(cyc);
    end
    if (op_en) begin
      op_cnt++;
      op_cyc = cyc;
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  task automatic fail_timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timeout waiting for DUT", name);
  endtask

  task automatic reset_log();
    wq.delete();
    wc.delete();
    op_cnt = 0;
    op_cyc = -1;
  endtask

  task automatic send(input vec_t v, input bit last, output int acc);
    op_type = v.op; padding = v.pad; stride = v.stride; op_num = v.op_num;
    i_channel_size = v.ich; o_channel_size = v.och; i_side_size = v.iside;
    o_side_size = v.oside; o_surf_size = v.surf; weight_start_addr = v.wa;
    data_start_addr = v.da; result_addr = v.ra; desc_last = last; desc_valid = 1'b1;
    acc = -1;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (desc_ready) begin
        acc = cyc;
        break;
      end
    end
    if (acc < 0) fail_timeout("send");
    @(posedge clk);
    #1;
    desc_valid = 1'b0;
  endtask

  task automatic wait_op(input int target);
    bit seen = 0;
    for (int k = 0; k < 300; k++) begin
      @(posedge clk);
      #1;
      if (op_cnt >= target) begin
        seen = 1;
        break;
      end
    end
    if (!seen) fail_timeout("wait_op");
  endtask

  task automatic wait_words(input int n);
    bit seen = 0;
    for (int k = 0; k < 300; k++) begin
      @(posedge clk);
      #1;
      if (wq.size() >= n) begin
        seen = 1;
        break;
      end
    end
    if (!seen) fail_timeout("wait_words");
  endtask

  task automatic chk_words(input string tag, input int base, input vec_t v);
    logic [31:0] got;
    for (int j = 0; j < 6; j++) begin
      got = (base + j < wq.size()) ? wq[base + j] : 32'hxxxxxxxx;
      chk($sformatf("%s_w%0d", tag, j), got, v.exp[j]);
    end
  endtask

  task automatic clr();
    batch_clr = 1'b1;
    @(posedge clk);
    #1;
    batch_clr = 1'b0;
  endtask

  initial begin
    int acc, acc2, bad;
    vec_t bv;
    vecs[0] = '{op: 3'd2, pad: 1'b1, stride: 4'd1, op_num: 20'h00ABC, ich: 16'd3, och: 16'd64,
                iside: 8'd227, oside: 8'd113, surf: 16'd12769, wa: 32'h1000, da: 32'hA0000,
                ra: 32'hC0000, exp: '{32'h00ABC112, 32'h00400003, 32'h31E171E3,
                                      32'h00001000, 32'h000A0000, 32'h000C0000}};
    vecs[1] = '{op: 3'd4, pad: 1'b0, stride: 4'd2, op_num: 20'hFFFFF, ich: 16'hFFFF,
                och: 16'h0001, iside: 8'h10, oside: 8'h08, surf: 16'h0040, wa: 32'hDEADBEEF,
                da: 32'h12345678, ra: 32'hFFFFFFFF, exp: '{32'hFFFFF204, 32'h0001FFFF,
                32'h00400810, 32'hDEADBEEF, 32'h12345678, 32'hFFFFFFFF}};
    vecs[2] = '{op: 3'd5, pad: 1'b1, stride: 4'hF, op_num: 20'h00001, ich: 16'h1234,
                och: 16'hABCD, iside: 8'hFF, oside: 8'h01, surf: 16'hFFFF, wa: 32'h0,
                da: 32'h80000000, ra: 32'h4, exp: '{32'h00001F15, 32'hABCD1234,
                32'hFFFF01FF, 32'h00000000, 32'h80000000, 32'h00000004}};
    vecs[3] = '{op: 3'd1, pad: 1'b0, stride: 4'd0, op_num: 20'h80001, ich: 16'h0, och: 16'h0,
                iside: 8'h5A, oside: 8'hA5, surf: 16'h8001, wa: 32'h11111111,
                da: 32'h22222222, ra: 32'h33333333, exp: '{32'h80001001, 32'h00000000,
                32'h8001A55A, 32'h11111111, 32'h22222222, 32'h33333333}};

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_wr_en", 32'(cmd_fifo_wr_en), 0);
    chk("rst_din", cmd_fifo_din, 0);
    chk("rst_cmd_size", 32'(cmd_size), 0);
    chk("rst_op_en", 32'(op_en), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_busy", 32'(busy), 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_ready", 32'(desc_ready), 1);

    // Table: one last descriptor per vector
    for (int i = 0; i < 4; i++) begin
      reset_log();
      send(vecs[i], 1'b1, acc);
      wait_op(1);
      chk($sformatf("v%0d_nwords", i), 32'(wq.size()), 6);
      chk_words($sformatf("v%0d", i), 0, vecs[i]);
      if (wc.size() == 6) begin
        chk($sformatf("v%0d_first_cyc", i), 32'(wc[0] - acc), 1);
        chk($sformatf("v%0d_last_cyc", i), 32'(wc[5] - acc), 6);
      end else fail_timeout($sformatf("v%0d_cycles", i));
      chk($sformatf("v%0d_op_cyc", i), 32'(op_cyc - acc), 7);
      chk($sformatf("v%0d_cmd_size", i), 32'(cmd_size), 1);
      chk($sformatf("v%0d_ready_armed", i), 32'(desc_ready), 0);
      chk($sformatf("v%0d_err", i), 32'(err), 0);
      clr();
      chk($sformatf("v%0d_clr_size", i), 32'(cmd_size), 0);
      chk($sformatf("v%0d_clr_ready", i), 32'(desc_ready), 1);
    end

    // Three back-to-back descriptors
    reset_log();
    send(vecs[0], 1'b0, acc);
    send(vecs[1], 1'b0, acc2);
    chk("b2b_spacing", 32'(acc2 - acc), 7);
    send(vecs[2], 1'b1, acc);
    wait_op(1);
    chk("b2b_nwords", 32'(wq.size()), 18);
    chk_words("b2b0", 0, vecs[0]);
    chk_words("b2b1", 6, vecs[1]);
    chk_words("b2b2", 12, vecs[2]);
    chk("b2b_cmd_size", 32'(cmd_size), 3);
    repeat (4) @(posedge clk);
    #1;
    chk("b2b_ready_held", 32'(desc_ready), 0);
    chk("b2b_op_cnt", 32'(op_cnt), 1);
    clr();

    // FIFO full for 5 cycles after word 2
    reset_log();
    send(vecs[0], 1'b1, acc);
    wait_words(3);
    cmd_fifo_full = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("stall%0d_din", k), cmd_fifo_din, vecs[0].exp[3]);
      chk($sformatf("stall%0d_wr_en", k), 32'(cmd_fifo_wr_en), 0);
      @(posedge clk);
      #1;
    end
    cmd_fifo_full = 1'b0;
    wait_op(1);
    chk("stall_nwords", 32'(wq.size()), 6);
    chk_words("stall", 0, vecs[0]);
    chk("stall_op_cyc", 32'(op_cyc - acc), 12);
    clr();

    // Invalid op followed by a valid maxpool
    reset_log();
    bv = vecs[1];
    bv.op = 3'd7;
    send(bv, 1'b0, acc);
    chk("inv_err", 32'(err), 1);
    chk("inv_busy", 32'(busy), 0);
    clr();
    chk("inv_clr_ignored", 32'(err), 1);
    send(vecs[1], 1'b1, acc);
    wait_op(1);
    chk("inv_nwords", 32'(wq.size()), 6);
    chk_words("inv", 0, vecs[1]);
    chk("inv_cmd_size", 32'(cmd_size), 1);
    chk("inv_err_kept", 32'(err), 1);
    clr();
    chk("inv_clr_err", 32'(err), 0);
    chk("inv_clr_size", 32'(cmd_size), 0);

    // Empty batch: invalid last descriptor
    reset_log();
    bv.op = 3'd0;
    send(bv, 1'b1, acc);
    wait_op(1);
    chk("empty_op_cyc", 32'(op_cyc - acc), 1);
    chk("empty_nwords", 32'(wq.size()), 0);
    chk("empty_err", 32'(err), 1);
    chk("empty_cmd_size", 32'(cmd_size), 0);
    clr();

    // Overflow: 127 commands without last
    reset_log();
    for (int i = 0; i < 127; i++) send(vecs[i % 4], 1'b0, acc);
    wait_op(1);
    repeat (10) @(posedge clk);
    #1;
    chk("ovf_nwords", 32'(wq.size()), 762);
    bad = 0;
    for (int i = 0; i < 127; i++)
      for (int j = 0; j < 6; j++)
        if (i * 6 + j >= wq.size() || wq[i * 6 + j] !== vecs[i % 4].exp[j]) bad++;
    chk("ovf_word_errs", 32'(bad), 0);
    chk("ovf_cmd_size", 32'(cmd_size), 127);
    chk("ovf_err", 32'(err), 1);
    chk("ovf_op_cnt", 32'(op_cnt), 1);
    chk("ovf_ready", 32'(desc_ready), 0);
    clr();

    // Reset in the middle of a command
    reset_log();
    send(vecs[1], 1'b0, acc);
    bv.op = 3'd6;
    send(bv, 1'b0, acc);
    send(vecs[0], 1'b1, acc);
    wait_words(10);
    chk("mid_pre_size", 32'(cmd_size), 1);
    rst = 1'b1;
    #1;
    chk("mid_wr_en", 32'(cmd_fifo_wr_en), 0);
    chk("mid_din", cmd_fifo_din, 0);
    chk("mid_cmd_size", 32'(cmd_size), 0);
    chk("mid_err", 32'(err), 0);
    chk("mid_busy", 32'(busy), 0);
    chk("mid_op_en", 32'(op_en), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("mid_op_cnt", 32'(op_cnt), 0);
    reset_log();
    send(vecs[2], 1'b1, acc);
    wait_op(1);
    chk("post_nwords", 32'(wq.size()), 6);
    chk_words("post", 0, vecs[2]);
    chk("post_cmd_size", 32'(cmd_size), 1);
    chk("post_err", 32'(err), 0);
    clr();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
